data_sram_responder: RTL

Responder for the core's data-SRAM initiator port: accepts `data_sram_en/wen/addr/wdata` requests and returns `data_sram_rdata` with fixed one-cycle latency. Requests are decoded to an on-chip word-addressed RAM with byte-lane writes, or to a small memory-mapped confreg window (LEDs, switches, free-running timer with compare interrupt, scratch register). Sits at SoC level beside `mycpu_core`, driven directly by its data-SRAM outputs.

---
 rtl/data_sram_if.sv | 12 +
 rtl/data_sram_responder.sv | 106 ++++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle between the core's data port and its responder.
// The core drives the request fields; the responder returns registered read data.
interface data_sram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// One-cycle-latency data-SRAM responder: byte-lane RAM plus a small confreg window
// (LEDs, synchronised switches, timer with sticky compare interrupt, scratch).
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        rst,
    data_sram_if.slave  bus,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        timer_int
);
    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_SWITCH  = 16'hf004;
    localparam logic [15:0] OFF_TIMER   = 16'he000;
    localparam logic [15:0] OFF_COMPARE = 16'he004;
    localparam logic [15:0] OFF_SCRATCH = 16'he008;

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] idx;
    logic [15:0]       off;
    logic              is_conf;
    logic              wr;
    logic              wr_timer, wr_compare, wr_scratch, wr_led;
    logic [31:0]       timer, compare, scratch;
    logic [31:0]       timer_inc;
    logic [7:0]        sw_s1, sw_s2;
    logic [31:0]       conf_rd;
    logic [31:0]       rd_word;

    // Replace the enabled byte lanes of cur with the matching lanes of wd.
    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign idx        = bus.addr[RAM_AW+1:2];
    assign off        = bus.addr[15:0];
    assign is_conf    = (bus.addr[31:16] == CONF_BASE);
    assign wr         = bus.en && (bus.wen != 4'b0);
    assign wr_timer   = wr && is_conf && (off == OFF_TIMER);
    assign wr_compare = wr && is_conf && (off == OFF_COMPARE);
    assign wr_scratch = wr && is_conf && (off == OFF_SCRATCH);
    assign wr_led     = wr && is_conf && (off == OFF_LED);
    assign timer_inc  = timer + 32'd1;

    // RAM is never reset; a request landing on a reset edge is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr && !is_conf)
            mem[idx] <= merge(mem[idx], bus.wdata, bus.wen);
    end

    always_comb begin
        conf_rd = '0;
        unique case (off)
            OFF_LED:     conf_rd = {16'b0, led};
            OFF_SWITCH:  conf_rd = {24'b0, sw_s2};
            OFF_TIMER:   conf_rd = timer;
            OFF_COMPARE: conf_rd = compare;
            OFF_SCRATCH: conf_rd = scratch;
            default:     conf_rd = '0;
        endcase
    end

    // Reads use pre-edge state, so a write request returns the old contents.
    assign rd_word = is_conf ? conf_rd : mem[idx];

    always_ff @(posedge clk) begin
        if (rst)
            bus.rdata <= '0;
        else if (bus.en)
            bus.rdata <= rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= '0;
            timer     <= '0;
            compare   <= 32'hffff_ffff;
            scratch   <= '0;
            timer_int <= 1'b0;
            sw_s1     <= '0;
            sw_s2     <= '0;
        end else begin
            timer <= wr_timer ? merge(timer_inc, bus.wdata, bus.wen) : timer_inc;
            if (wr_compare) compare <= merge(compare, bus.wdata, bus.wen);
            if (wr_scratch) scratch <= merge(scratch, bus.wdata, bus.wen);
            if (wr_led) begin
                if (bus.wen[0]) led[7:0]  <= bus.wdata[7:0];
                if (bus.wen[1]) led[15:8] <= bus.wdata[15:8];
            end
            // Clearing via a COMPARE write takes priority over a same-cycle match.
            if (wr_compare)
                timer_int <= 1'b0;
            else if (timer == compare)
                timer_int <= 1'b1;
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
        end
    end
endmodule
